pmem_arbiter: RTL
=================

// Module: pmem_arbiter
// PURPOSE
//  Shares the single line-wide physical-memory port (to the cacheline adaptor) between icache and dcache.
//  Sequences one whole line transaction at a time: dcache read/writeback or icache fill.
//  Sits in mp4 top between {icache, dcache} pmem sides and the cacheline adaptor.
// PARAMETERS
//  ADDR_W  32   physical address width
//  LINE_W  256  cache line width (one transaction = one line)
// PORTS
//  clk             in   1       clock; all state updates on posedge
//  rst             in   1       synchronous, active-high reset
//  i_pmem_read     in   1       icache line-fill request, held until i_pmem_resp
//  i_pmem_address  in   ADDR_W  icache line address
//  i_pmem_rdata    out  LINE_W  fill data (valid with i_pmem_resp)
//  i_pmem_resp     out  1       icache transaction done, 1-cycle pulse
//  d_pmem_read     in   1       dcache line-read request, held until d_pmem_resp
//  d_pmem_write    in   1       dcache writeback request, held until d_pmem_resp
//  d_pmem_address  in   ADDR_W  dcache line address
//  d_pmem_wdata    in   LINE_W  writeback data
//  d_pmem_rdata    out  LINE_W  read data (valid with d_pmem_resp)
//  d_pmem_resp     out  1       dcache transaction done, 1-cycle pulse
//  pmem_read       out  1       to adaptor: line read
//  pmem_write      out  1       to adaptor: line write
//  pmem_address    out  ADDR_W  to adaptor: address of granted client
//  pmem_wdata      out  LINE_W  to adaptor: dcache wdata (don't-care when icache granted)
//  pmem_rdata      in   LINE_W  from adaptor
//  pmem_resp       in   1       from adaptor: transaction done, 1-cycle pulse
//  arb_busy        out  1       state != ARB_IDLE (perf/debug)
// BEHAVIOUR
//  - FSM states ARB_IDLE, ARB_I, ARB_D; state registered, all pmem_* outputs decoded combinationally from state.
//  - Reset: state <= ARB_IDLE; in cycle after reset edge pmem_read=pmem_write=0, i/d_pmem_resp=0, arb_busy=0.
//  - ARB_IDLE: no pmem request driven. d req (read|write) -> ARB_D; else i_pmem_read -> ARB_I; else stay.
//    Arbitration latency: request seen in IDLE at cycle t, pmem_read/write asserted at t+1.
//  - ARB_D: pmem_read=d_pmem_read, pmem_write=d_pmem_write, address/wdata from dcache.
//    ARB_I: pmem_read=1, pmem_write=0, address from icache.
//  - pmem_resp in ARB_x: same-cycle (combinational) resp pulse to granted client only; next state ARB_IDLE.
//    Mandatory one idle cycle between transactions, so adaptor never sees a request in the cycle after resp.
//  - pmem_rdata broadcast to i_pmem_rdata and d_pmem_rdata; only the resp is gated.
//  - Non-granted client waits with request held; no request is dropped or reordered within a client.
//  - Request deasserted mid-transaction by granted client: illegal (assertion); FSM still waits for pmem_resp.
//  - d_pmem_read & d_pmem_write together: illegal (assertion).
//  - pmem_resp in ARB_IDLE: ignored, no client resp (assertion flags it).
//  - rst mid-transaction: abandons grant, ARB_IDLE next cycle; adaptor and caches reset by same rst.
// CONFIGURATION
//  PMEM_ARB_RR_EN undefined: fixed priority, dcache wins every simultaneous IDLE request.
//  PMEM_ARB_RR_EN defined: 1-bit last_grant reg (reset = icache); on simultaneous IDLE request the client
//    NOT served last wins; last_grant updates when a transaction completes (pmem_resp). Single requester
//    is granted regardless of last_grant.
// STRUCTURE
//  pmem_arb_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_I, ARB_D} arb_state_t;
//    typedef enum logic {CLI_I, CLI_D} arb_client_t; default ADDR_W/LINE_W constants.
//  One sub-module: pmem_arb_pick (combinational next-grant select from i_req, d_req, last_grant).
// TESTING
//  1 i_pmem_read=1 addr 0x0000_0060, adaptor resp after 8 cycles -> pmem_read at t+1, i_pmem_resp pulse
//    same cycle as pmem_resp, i_pmem_rdata==pmem_rdata, d_pmem_resp stays 0.
//  2 i_pmem_read and d_pmem_write (addr 0x0000_1000, wdata 0xA5..A5) at same cycle, no RR -> dcache
//    write first, pmem_wdata=0xA5..A5; one IDLE cycle; then icache read.
//  3 Same as 2 with PMEM_ARB_RR_EN, after a prior dcache transaction -> icache first, then dcache.
//  4 Back-to-back: dcache reissues d_pmem_read the cycle after d_pmem_resp while icache waits
//    -> fixed: dcache again; RR: icache; never pmem_read in cycle after pmem_resp.
//  5 rst pulsed 3 cycles into ARB_D -> next cycle pmem_read=pmem_write=0, arb_busy=0,
//    no resp pulses; fresh icache request then served normally.
//  6 pmem_resp injected while ARB_IDLE -> no i/d resp pulse, assertion fires.

Source files
------------

// File: rtl/pmem_arbiter_pkg.sv
// Shared types and default widths for the pmem arbiter slice (icache/dcache -> cacheline adaptor).
package pmem_arb_pkg;

    localparam int PMEM_ADDR_W = 32;
    localparam int PMEM_LINE_W = 256;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_I    = 2'd1,
        ARB_D    = 2'd2
    } arb_state_t;

    typedef enum logic {
        CLI_I = 1'b0,
        CLI_D = 1'b1
    } arb_client_t;

    function automatic arb_client_t other_client(input arb_client_t c);
        return (c == CLI_I) ? CLI_D : CLI_I;
    endfunction

endpackage

// File: rtl/pmem_arbiter_if.sv
// Line-wide physical-memory channel; master issues read/write, slave answers with rdata/resp.
interface pmem_arbiter_if
    import pmem_arb_pkg::*;
#(
    parameter int ADDR_W = PMEM_ADDR_W,
    parameter int LINE_W = PMEM_LINE_W
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              resp;

    modport master (output read, output write, output address, output wdata,
                    input  rdata, input  resp);
    modport slave  (input  read, input  write, input  address, input  wdata,
                    output rdata, output resp);
endinterface

// File: rtl/pmem_arbiter_chk.sv
// Protocol checker for the arbiter; idle-resp events are also latched in idle_resp_seen_r.
module pmem_arb_chk
    import pmem_arb_pkg::*;
#(
    parameter bit IDLE_RESP_FATAL = 1'b1
) (
    input logic       clk,
    input logic       rst,
    input arb_state_t state,
    input logic       i_read,
    input logic       i_write,
    input logic       d_read,
    input logic       d_write,
    input logic       pmem_resp
);

    logic idle_resp_seen_r;

    // Sticky record of an adaptor response arriving with no grant outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_resp_seen_r <= 1'b0;
        end else if (pmem_resp && (state == ARB_IDLE)) begin
            idle_resp_seen_r <= 1'b1;
        end else begin
            idle_resp_seen_r <= idle_resp_seen_r;
        end
    end

    a_d_rw_excl: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
    a_i_no_write: assert property (@(posedge clk) disable iff (rst) !i_write);
    a_d_held: assert property (@(posedge clk) disable iff (rst) (state == ARB_D) |-> (d_read || d_write));
    a_i_held: assert property (@(posedge clk) disable iff (rst) (state == ARB_I) |-> i_read);
    a_idle_resp: assert property (@(posedge clk) disable iff (rst || !IDLE_RESP_FATAL)
                                  !(pmem_resp && (state == ARB_IDLE)));

endmodule

// File: rtl/pmem_arbiter_pick.sv
// Combinational next-grant select; RR_EN chooses between dcache-first and alternate-on-contention.
module pmem_arb_pick
    import pmem_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic        i_req,
    input  logic        d_req,
    input  arb_client_t last_grant,
    output logic        grant_valid,
    output arb_client_t grant
);

    // Pick the winner among the pending requesters
    always_comb begin
        grant_valid = i_req | d_req;
        grant       = CLI_D;
        if (i_req && d_req) begin
            if (RR_EN) begin
                grant = other_client(last_grant);
            end else begin
                grant = CLI_D;
            end
        end else if (i_req) begin
            grant = CLI_I;
        end else begin
            grant = CLI_D;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one line-wide pmem port between icache and dcache, one whole line transaction at a time.
// Define PMEM_ARB_RR_EN for alternating grant on contention; default is dcache-first.
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter bit IDLE_RESP_FATAL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    pmem_arbiter_if.slave         icache,
    pmem_arbiter_if.slave         dcache,
    pmem_arbiter_if.master        mem,
    output logic                  arb_busy
);

    arb_state_t  state_r;
    arb_client_t last_grant_s;
    arb_client_t grant_s;
    logic        grant_valid_s;
    logic        i_req_s;
    logic        d_req_s;

    assign i_req_s = icache.read;
    assign d_req_s = dcache.read | dcache.write;

`ifdef PMEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
    arb_client_t last_grant_r;

    // Remember which client completed most recently
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= CLI_I;
        end else if (mem.resp && (state_r == ARB_I)) begin
            last_grant_r <= CLI_I;
        end else if (mem.resp && (state_r == ARB_D)) begin
            last_grant_r <= CLI_D;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign last_grant_s = last_grant_r;
`else
    localparam bit RR_EN = 1'b0;
    assign last_grant_s = CLI_I;
`endif

    pmem_arb_pick #(.RR_EN(RR_EN)) u_pick (
        .i_req       (i_req_s),
        .d_req       (d_req_s),
        .last_grant  (last_grant_s),
        .grant_valid (grant_valid_s),
        .grant       (grant_s)
    );

    // Grant FSM; always returns to IDLE after a response so transactions are separated by a cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ARB_IDLE;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (grant_valid_s) begin
                        state_r <= (grant_s == CLI_D) ? ARB_D : ARB_I;
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_I, ARB_D: begin
                    if (mem.resp) begin
                        state_r <= ARB_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: state_r <= ARB_IDLE;
            endcase
        end
    end

    // Route the granted client onto the adaptor port and gate the response back to it
    always_comb begin
        mem.read     = 1'b0;
        mem.write    = 1'b0;
        mem.address  = icache.address;
        mem.wdata    = dcache.wdata;
        icache.resp  = 1'b0;
        dcache.resp  = 1'b0;
        arb_busy     = 1'b1;
        case (state_r)
            ARB_IDLE: begin
                arb_busy = 1'b0;
            end
            ARB_I: begin
                mem.read    = 1'b1;
                icache.resp = mem.resp;
            end
            ARB_D: begin
                mem.read    = dcache.read;
                mem.write   = dcache.write;
                mem.address = dcache.address;
                dcache.resp = mem.resp;
            end
            default: begin
                arb_busy = 1'b0;
            end
        endcase
    end

    assign icache.rdata = mem.rdata;
    assign dcache.rdata = mem.rdata;

    pmem_arb_chk #(.IDLE_RESP_FATAL(IDLE_RESP_FATAL)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .state     (state_r),
        .i_read    (icache.read),
        .i_write   (icache.write),
        .d_read    (dcache.read),
        .d_write   (dcache.write),
        .pmem_resp (mem.resp)
    );

endmodule
